bcd_seg_scan: RTL and testbench

Multiplexed 7-segment display driver for N_DIG BCD digits, e.g. the 4-bit outputs of the up/down BCD counters.
- Latches a packed BCD word on a load strobe.
- Scans digits one at a time with a programmable dwell time and a one-cycle anti-ghost blanking slot between digits.
- Decodes each digit to active-high segments and flags illegal BCD codes.
- Sits between the counter datapath and the board display pins.

---
 rtl/bcd_seg_scan.sv | 132 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_scan
// Purpose  : Multiplexed 7-segment driver for N_DIG BCD digits with
//            anti-ghost blanking. Optional macro LZ_BLANK_EN adds
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seg_scan #(
    parameter int N_DIG    = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [4*N_DIG-1:0] bcd_in,
    output logic [N_DIG-1:0]   dig_sel,
    output logic [6:0]         seg,
    output logic               err
);

    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] c_idx_last = IW'(N_DIG - 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t             r_state, w_state;
    logic [IW-1:0]      r_idx, w_idx, w_nidx;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic [4*N_DIG-1:0] r_shadow, w_src;
    logic [N_DIG-1:0]   r_dig_sel, w_dig_sel;
    logic [6:0]         r_seg, w_seg;
    logic               r_err, w_err;
    logic [3:0]         w_code;
`ifdef LZ_BLANK_EN
    logic               w_upper_zero;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        // A load on the sampling edge must be decoded directly from bcd_in.
        w_src  = load ? bcd_in : r_shadow;
        w_nidx = (r_idx == c_idx_last) ? '0 : r_idx + IW'(1);
        w_code = 4'd0;
`ifdef LZ_BLANK_EN
        w_upper_zero = 1'b1;
`endif
        for (int k = 0; k < N_DIG; k++) begin
            if (IW'(k) == w_nidx) w_code = w_src[4*k +: 4];
`ifdef LZ_BLANK_EN
            if (IW'(k) > w_nidx && w_src[4*k +: 4] != 4'd0) w_upper_zero = 1'b0;
`endif
        end

        w_state   = r_state;
        w_idx     = r_idx;
        w_cnt     = r_cnt;
        w_dig_sel = r_dig_sel;
        w_seg     = r_seg;
        w_err     = r_err;

        case (r_state)
            ST_BLANK: begin
                w_state   = ST_SHOW;
                w_idx     = w_nidx;
                w_cnt     = '0;
                w_dig_sel = N_DIG'(1) << w_nidx;
                w_seg     = decode(w_code);
`ifdef LZ_BLANK_EN
                if (w_nidx != '0 && w_code == 4'd0 && w_upper_zero) w_seg = 7'd0;
`endif
                if (w_code > 4'd9) w_err = 1'b1;
            end
            ST_SHOW: begin
                if (r_cnt == c_cnt_last) begin
                    w_state   = ST_BLANK;
                    w_dig_sel = '0;
                    w_seg     = 7'd0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: w_state = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_BLANK;
            r_idx     <= c_idx_last;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_dig_sel <= '0;
            r_seg     <= 7'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_cnt     <= w_cnt;
            r_shadow  <= w_src;
            r_dig_sel <= w_dig_sel;
            r_seg     <= w_seg;
            r_err     <= w_err;
        end
    end

    assign dig_sel = r_dig_sel;
    assign seg     = r_seg;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seg_scan
// Purpose  : Directed self-checking bench for bcd_seg_scan (N_DIG=4,
//            SCAN_DIV=4, frame = 20 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                           S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                           S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111,
                           S9 = 7'b1101111, SD = 7'b1000000, SB = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dig_sel;
    logic [6:0]  seg;
    logic        err;

    int tests = 0;
    int failed = 0;

    bcd_seg_scan #(.N_DIG(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .dig_sel(dig_sel), .seg(seg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for cycle i of a frame that starts with digit 0 SHOW.
    function automatic logic [3:0] exp_sel(input int i);
        logic [3:0] one;
        one = 4'b0001;
        if (i % 5 == 4) return 4'b0000;
        return one << (i / 5);
    endfunction

    function automatic logic [6:0] exp_seg(input int i, input logic [6:0] e0, e1, e2, e3);
        if (i % 5 == 4) return SB;
        case (i / 5)
            0: return e0;
            1: return e1;
            2: return e2;
            default: return e3;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; load = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; bcd_in = 16'h9999;
        tick(); tick();
        tests++;
        if ({dig_sel, seg, err} !== {4'b0000, SB, 1'b0}) begin
            failed++;
            $display("FAIL reset_state: got sel=%b seg=%b err=%b, expected 0000 0000000 0", dig_sel, seg, err);
        end
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({dig_sel, seg, err} !== {exp_sel(i), exp_seg(i, S0, S0, S0, S0), 1'b0}) begin
                failed++;
                $display("FAIL scan_after_reset cyc %0d: got sel=%b seg=%b err=%b, expected sel=%b seg=%b err=0",
                         i, dig_sel, seg, err, exp_sel(i), exp_seg(i, S0, S0, S0, S0));
            end
        end
    endtask

    // Each value is loaded coincident with the BLANK->SHOW edge of digit 0.
    task automatic test_decode();
        logic [15:0] vals [3];
        logic [6:0]  exps [3][4];
        vals = '{16'h9876, 16'h5432, 16'h0010};
        exps = '{'{S6, S7, S8, S9}, '{S2, S3, S4, S5}, '{S0, S1, S0, S0}};
        do_reset();
        for (int v = 0; v < 3; v++) begin
            load = 1'b1; bcd_in = vals[v];
            for (int i = 0; i < 20; i++) begin
                tick();
                load = 1'b0;
                tests++;
                if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, exps[v][0], exps[v][1], exps[v][2], exps[v][3])}) begin
                    failed++;
                    $display("FAIL decode_%h cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b", vals[v], i,
                             dig_sel, seg, exp_sel(i), exp_seg(i, exps[v][0], exps[v][1], exps[v][2], exps[v][3]));
                end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        load = 1'b1; bcd_in = 16'h00A0;
        for (int i = 0; i < 20; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({dig_sel, seg, err} !== {exp_sel(i), exp_seg(i, S0, SD, S0, S0), (i >= 5)}) begin
                failed++;
                $display("FAIL illegal_00A0 cyc %0d: got sel=%b seg=%b err=%b, expected sel=%b seg=%b err=%b",
                         i, dig_sel, seg, err, exp_sel(i), exp_seg(i, S0, SD, S0, S0), (i >= 5));
            end
        end
        load = 1'b1; bcd_in = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({dig_sel, seg, err} !== {exp_sel(i), exp_seg(i, S0, S0, S0, S0), 1'b1}) begin
                failed++;
                $display("FAIL err_sticky cyc %0d: got sel=%b seg=%b err=%b, expected sel=%b seg=%b err=1",
                         i, dig_sel, seg, err, exp_sel(i), exp_seg(i, S0, S0, S0, S0));
            end
        end
        do_reset();
        tests++;
        if (err !== 1'b0) begin
            failed++;
            $display("FAIL err_clear_by_rst: got err=%b, expected 0", err);
        end
    endtask

    task automatic test_load_timing();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, S0, S0, S0, S0)}) begin
                failed++;
                $display("FAIL load_mid_show cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b",
                         i, dig_sel, seg, exp_sel(i), exp_seg(i, S0, S0, S0, S0));
            end
            if (i == 1) begin
                load = 1'b1; bcd_in = 16'h0003;
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, S3, S0, S0, S0)}) begin
                failed++;
                $display("FAIL load_next_show cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b",
                         i, dig_sel, seg, exp_sel(i), exp_seg(i, S3, S0, S0, S0));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        load = 1'b1; bcd_in = 16'h1234;
        for (int i = 0; i < 12; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, S4, S3, S2, S1)}) begin
                failed++;
                $display("FAIL pre_reset_1234 cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b",
                         i, dig_sel, seg, exp_sel(i), exp_seg(i, S4, S3, S2, S1));
            end
        end
        rst = 1'b1; load = 1'b1; bcd_in = 16'h9999;
        tick();
        tests++;
        if ({dig_sel, seg, err} !== {4'b0000, SB, 1'b0}) begin
            failed++;
            $display("FAIL mid_scan_reset: got sel=%b seg=%b err=%b, expected 0000 0000000 0", dig_sel, seg, err);
        end
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, S0, S0, S0, S0)}) begin
                failed++;
                $display("FAIL restart_after_reset cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b",
                         i, dig_sel, seg, exp_sel(i), exp_seg(i, S0, S0, S0, S0));
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] a3, b1, b2, b3;
`ifdef LZ_BLANK_EN
        a3 = SB; b1 = SB; b2 = SB; b3 = SB;
`else
        a3 = S0; b1 = S0; b2 = S0; b3 = S0;
`endif
        do_reset();
        load = 1'b1; bcd_in = 16'h0105;
        for (int i = 0; i < 20; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, S5, S0, S1, a3)}) begin
                failed++;
                $display("FAIL lz_0105 cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b",
                         i, dig_sel, seg, exp_sel(i), exp_seg(i, S5, S0, S1, a3));
            end
        end
        load = 1'b1; bcd_in = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({dig_sel, seg} !== {exp_sel(i), exp_seg(i, S0, b1, b2, b3)}) begin
                failed++;
                $display("FAIL lz_0000 cyc %0d: got sel=%b seg=%b, expected sel=%b seg=%b",
                         i, dig_sel, seg, exp_sel(i), exp_seg(i, S0, b1, b2, b3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_load_timing();
        test_mid_reset();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
